// File: rtl/pio_dtack_responder_pkg.sv
// pio_dtack_responder_pkg: shared state, region codes and window base addresses
package pio_dtack_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;
  typedef enum logic [2:0] {R_PIO, R_DEV, R_USB, R_DBG, R_INTC, R_UNMAPPED} region_t;
  localparam logic [23:0] BASE_PIO  = 24'hFF8000;
  localparam logic [23:0] BASE_DEV  = 24'hFF9000;
  localparam logic [23:0] BASE_USB  = 24'hFFA000;
  localparam logic [23:0] BASE_INTC = 24'hFFB000;
endpackage

// File: rtl/pio_dtack_responder_region_map.sv
// pio_region_map: decode adm/adl into a region code and its wait-state count
module pio_region_map
  import pio_dtack_responder_pkg::*;
#(
  parameter int WAIT_PIO  = 0,
  parameter int WAIT_DEV  = 2,
  parameter int WAIT_USB  = 1,
  parameter int WAIT_INTC = 0,
  parameter int CNT_W     = 8
) (
  input  logic [2:0]       adm,
  input  logic [1:0]       adl,
  output region_t          region,
  output logic [CNT_W-1:0] wait_val
);
  // region decode; only adl=0 of the adm=2 block is the USB FIFO, adl=1 is a hole
  always_comb begin
    region = adm == 3'd0 ? R_PIO :
             adm == 3'd1 ? R_DEV :
             adm == 3'd2 ? (adl == 2'd0 ? R_USB : adl == 2'd1 ? R_UNMAPPED : R_DBG) :
             adm == 3'd3 ? R_INTC : R_UNMAPPED;
    wait_val = (region == R_PIO || region == R_DBG) ? CNT_W'(WAIT_PIO) :
               region == R_DEV  ? CNT_W'(WAIT_DEV) :
               region == R_USB  ? CNT_W'(WAIT_USB) :
               region == R_INTC ? CNT_W'(WAIT_INTC) : '0;
  end
endmodule

// File: rtl/pio_dtack_responder.sv
// pio_dtack_responder: times peripheral-window accesses and returns DTACK or BERR
module pio_dtack_responder
  import pio_dtack_responder_pkg::*;
#(
  parameter int WAIT_PIO  = 0,
  parameter int WAIT_DEV  = 2,
  parameter int WAIT_USB  = 1,
  parameter int WAIT_INTC = 0,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic [2:0] adm,
  input  logic [1:0] adl,
  input  logic       usb_ready,
  output logic       dtack_n,
  output logic       berr_n,
  output logic       busy,
  output logic [7:0] berr_count
);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  state_t           state, state_nx;
  region_t          region_d, region_q;
  logic [CNT_W-1:0] wait_val, wait_cnt, wait_nx, tmo_cnt, tmo_nx;
  logic             start;
  assign start = cs & ~as_n & (~uds_n | ~lds_n);
  assign busy  = state != S_IDLE;
  pio_region_map #(
    .WAIT_PIO (WAIT_PIO),
    .WAIT_DEV (WAIT_DEV),
    .WAIT_USB (WAIT_USB),
    .WAIT_INTC(WAIT_INTC),
    .CNT_W    (CNT_W)
  ) u_map (
    .adm     (adm),
    .adl     (adl),
    .region  (region_d),
    .wait_val(wait_val)
  );
  // next state and counter updates; WAIT checks abort, then timeout, then wait states
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    tmo_nx   = tmo_cnt;
    case (state)
      S_IDLE: if (start) begin
        state_nx = region_d == R_UNMAPPED ? S_ERR : S_WAIT;
        wait_nx  = wait_val;
        tmo_nx   = '0;
      end
      S_WAIT: begin
        tmo_nx = tmo_cnt + 1'b1;
        if (as_n) state_nx = S_IDLE;
        else if (tmo_cnt == TMO_LAST) state_nx = S_ERR;
        else if (wait_cnt != '0) wait_nx = wait_cnt - 1'b1;
        else if (region_q != R_USB || usb_ready) state_nx = S_ACK;
      end
      default: state_nx = as_n ? S_IDLE : state;
    endcase
  end
  // state, counters and registered acknowledge outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      region_q   <= R_PIO;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      dtack_n    <= 1'b1;
      berr_n     <= 1'b1;
      berr_count <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      tmo_cnt  <= tmo_nx;
      dtack_n  <= state_nx != S_ACK;
      berr_n   <= state_nx != S_ERR;
      if (state == S_IDLE) region_q <= region_d;
      if (state_nx == S_ERR && state != S_ERR && berr_count != 8'hff) berr_count <= berr_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pio_dtack_responder.sv
// tb_pio_dtack_responder: directed self-checking bench for the DTACK/BERR responder
module tb_pio_dtack_responder;
  import pio_dtack_responder_pkg::*;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0;
  logic       as_n = 1'b1;
  logic       uds_n = 1'b1;
  logic       lds_n = 1'b1;
  logic [2:0] adm = '0;
  logic [1:0] adl = '0;
  logic       usb_ready = 1'b1;
  logic       dtack_n, berr_n, busy;
  logic [7:0] berr_count;
  logic [2:0] ref_adm = '0;
  logic [1:0] ref_adl = '0;
  region_t    ref_region;
  logic [7:0] ref_wait;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_dtack_responder #(
    .WAIT_PIO(0), .WAIT_DEV(2), .WAIT_USB(1), .WAIT_INTC(0), .TIMEOUT(64), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .adm(adm), .adl(adl), .usb_ready(usb_ready), .dtack_n(dtack_n), .berr_n(berr_n),
    .busy(busy), .berr_count(berr_count)
  );

  pio_region_map #(
    .WAIT_PIO(0), .WAIT_DEV(2), .WAIT_USB(1), .WAIT_INTC(0), .CNT_W(8)
  ) ref_map (
    .adm(ref_adm), .adl(ref_adl), .region(ref_region), .wait_val(ref_wait)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (!dtack_n && !berr_n) begin
        errors++;
        $display("FAIL exclusive: dtack_n=%b berr_n=%b both low at %0t", dtack_n, berr_n, $time);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_access(input logic [23:0] addr, input logic rd);
    cs    = 1'b1;
    adm   = addr[14:12];
    adl   = addr[7:6];
    as_n  = 1'b0;
    lds_n = 1'b0;
    uds_n = rd ? 1'b0 : 1'b1;
  endtask

  task automatic end_access;
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (dtack_n !== 1'b1 || berr_n !== 1'b1 || busy !== 1'b0 || berr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: dtack_n=%b berr_n=%b busy=%b cnt=%0d, need 1 1 0 0", dtack_n, berr_n, busy, berr_count);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_region_map;
    logic [2:0] t_adm [7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd5};
    logic [1:0] t_adl [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2};
    region_t    t_reg [7] = '{R_PIO, R_DEV, R_USB, R_UNMAPPED, R_DBG, R_INTC, R_UNMAPPED};
    logic [7:0] t_wt  [7] = '{8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 7; i++) begin
      ref_adm = t_adm[i];
      ref_adl = t_adl[i];
      #1;
      checks++;
      if (ref_region !== t_reg[i] || ref_wait !== t_wt[i]) begin
        errors++;
        $display("FAIL region_map[%0d]: region=%0d wait=%0d, need %0d %0d", i, ref_region, ref_wait, t_reg[i], t_wt[i]);
      end
    end
  endtask

  task automatic test_pio_write;
    begin_access(BASE_PIO, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b1 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL pio_e0: busy=%b dtack_n=%b, need 1 1", busy, dtack_n);
    end
    tick();
    checks++;
    if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
      errors++;
      $display("FAIL pio_e1: dtack_n=%b berr_n=%b, need 0 1", dtack_n, berr_n);
    end
    end_access();
    tick();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0 || berr_count !== 8'd0) begin
      errors++;
      $display("FAIL pio_release: dtack_n=%b busy=%b cnt=%0d, need 1 0 0", dtack_n, busy, berr_count);
    end
  endtask

  task automatic test_dev_read;
    begin_access(BASE_DEV + 24'h40, 1'b1);
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (dtack_n !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL dev_e%0d: dtack_n=%b busy=%b, need 1 1", e, dtack_n, busy);
      end
    end
    tick();
    checks++;
    if (dtack_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dev_e3: dtack_n=%b busy=%b, need 0 1", dtack_n, busy);
    end
    end_access();
    tick();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dev_release: dtack_n=%b busy=%b, need 1 0", dtack_n, busy);
    end
  endtask

  task automatic test_usb;
    usb_ready = 1'b0;
    begin_access(BASE_USB, 1'b1);
    for (int e = 0; e <= 10; e++) begin
      tick();
      checks++;
      if (dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL usb_wait_e%0d: dtack_n=%b, need 1", e, dtack_n);
      end
    end
    usb_ready = 1'b1;
    tick();
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL usb_e11: dtack_n=%b, need 0", dtack_n);
    end
    end_access();
    tick();
    usb_ready = 1'b0;
    begin_access(BASE_USB, 1'b1);
    for (int e = 0; e <= 63; e++) tick();
    checks++;
    if (berr_n !== 1'b1 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL tmo_e63: berr_n=%b dtack_n=%b, need 1 1", berr_n, dtack_n);
    end
    tick();
    checks++;
    if (berr_n !== 1'b0 || dtack_n !== 1'b1 || berr_count !== 8'd1) begin
      errors++;
      $display("FAIL tmo_e64: berr_n=%b dtack_n=%b cnt=%0d, need 0 1 1", berr_n, dtack_n, berr_count);
    end
    end_access();
    tick();
    checks++;
    if (berr_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_release: berr_n=%b busy=%b, need 1 0", berr_n, busy);
    end
    usb_ready = 1'b1;
  endtask

  task automatic test_unmapped;
    logic [23:0] addrs [2] = '{BASE_USB + 24'h40, 24'hFFC000};
    for (int i = 0; i < 2; i++) begin
      begin_access(addrs[i], 1'b1);
      tick();
      tick();
      checks++;
      if (berr_n !== 1'b0 || dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL unmapped[%0d]: berr_n=%b dtack_n=%b, need 0 1", i, berr_n, dtack_n);
      end
      end_access();
      tick();
    end
    checks++;
    if (berr_count !== 8'd3 || berr_n !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_count: cnt=%0d berr_n=%b, need 3 1", berr_count, berr_n);
    end
  endtask

  task automatic test_abort;
    begin_access(BASE_DEV, 1'b1);
    tick();
    end_access();
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || dtack_n !== 1'b1 || berr_n !== 1'b1) begin
        errors++;
        $display("FAIL abort_e%0d: busy=%b dtack_n=%b berr_n=%b, need 0 1 1", e, busy, dtack_n, berr_n);
      end
    end
  endtask

  task automatic test_reset_in_ack;
    begin_access(BASE_PIO, 1'b1);
    tick();
    tick();
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack_pre: dtack_n=%b, need 0", dtack_n);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0 || berr_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_ack: dtack_n=%b busy=%b cnt=%0d, need 1 0 0", dtack_n, busy, berr_count);
    end
    end_access();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    begin_access(BASE_INTC, 1'b0);
    tick();
    tick();
    as_n = 1'b1;
    tick();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: dtack_n=%b busy=%b, need 1 0", dtack_n, busy);
    end
    as_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL b2b_e0: busy=%b dtack_n=%b, need 1 1", busy, dtack_n);
    end
    tick();
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL b2b_e1: dtack_n=%b, need 0", dtack_n);
    end
    end_access();
    tick();
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      begin_access(24'hFFD000, 1'b1);
      tick();
      end_access();
      tick();
      if (i == 253 || i == 254) begin
        checks++;
        if (berr_count !== 8'(i + 1)) begin
          errors++;
          $display("FAIL sat_%0d: cnt=%0d, need %0d", i, berr_count, i + 1);
        end
      end
    end
    checks++;
    if (berr_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: cnt=%0d, need 255", berr_count);
    end
    begin_access(BASE_PIO, 1'b1);
    cs = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || dtack_n !== 1'b1 || berr_n !== 1'b1 || berr_count !== 8'd255) begin
        errors++;
        $display("FAIL cs_off_e%0d: busy=%b dtack_n=%b berr_n=%b cnt=%0d, need 0 1 1 255", e, busy, dtack_n, berr_n, berr_count);
      end
    end
    end_access();
    tick();
  endtask

  initial begin
    test_reset();
    test_region_map();
    test_pio_write();
    test_dev_read();
    test_usb();
    test_unmapped();
    test_abort();
    test_reset_in_ack();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
